// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, flush, bubble-gated control.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered Ready_Out.
module pipe_stage_reg #(
    parameter int                    CTRL_WIDTH = 8,
    parameter int                    DATA_WIDTH = 96,
    parameter logic [CTRL_WIDTH-1:0] CTRL_RESET = {CTRL_WIDTH{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    input  logic [CTRL_WIDTH-1:0] Ctrl_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic                  Valid_Out,
    input  logic                  Ready_In,
    output logic [CTRL_WIDTH-1:0] Ctrl_Out,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic [1:0]            Occupancy
);

    logic                  r_m_vld;
    logic [CTRL_WIDTH-1:0] r_m_ctrl;
    logic [DATA_WIDTH-1:0] r_m_data;

    logic                  w_m_vld_nxt;
    logic [CTRL_WIDTH-1:0] w_m_ctrl_nxt;
    logic [DATA_WIDTH-1:0] w_m_data_nxt;

    logic w_accept;
    logic w_drain;

    assign w_accept = Valid_In & Ready_Out;
    assign w_drain  = r_m_vld & Ready_In;

    // A bubble must never present live control bits downstream.
    assign Valid_Out = r_m_vld;
    assign Ctrl_Out  = r_m_vld ? r_m_ctrl : CTRL_RESET;
    assign Data_Out  = r_m_data;

`ifdef PIPE_STAGE_SKID_EN
    logic                  r_s_vld;
    logic [CTRL_WIDTH-1:0] r_s_ctrl;
    logic [DATA_WIDTH-1:0] r_s_data;
    logic [1:0]            r_occ;

    logic                  w_s_vld_nxt;
    logic [CTRL_WIDTH-1:0] w_s_ctrl_nxt;
    logic [DATA_WIDTH-1:0] w_s_data_nxt;
    logic [1:0]            w_occ_nxt;

    // Registered ready: no combinational path from Ready_In to Ready_Out.
    assign Ready_Out = ~r_s_vld;
    assign Occupancy = r_occ;

    always_comb begin
        w_m_vld_nxt  = r_m_vld;
        w_m_ctrl_nxt = r_m_ctrl;
        w_m_data_nxt = r_m_data;
        w_s_vld_nxt  = r_s_vld;
        w_s_ctrl_nxt = r_s_ctrl;
        w_s_data_nxt = r_s_data;
        if (Flush) begin
            w_m_vld_nxt = 1'b0;
            w_s_vld_nxt = 1'b0;
        end else if (w_drain && r_s_vld) begin
            w_m_vld_nxt  = 1'b1;
            w_m_ctrl_nxt = r_s_ctrl;
            w_m_data_nxt = r_s_data;
            if (w_accept) begin
                w_s_ctrl_nxt = Ctrl_In;
                w_s_data_nxt = Data_In;
            end else begin
                w_s_vld_nxt = 1'b0;
            end
        end else if (!r_m_vld || w_drain) begin
            if (w_accept) begin
                w_m_vld_nxt  = 1'b1;
                w_m_ctrl_nxt = Ctrl_In;
                w_m_data_nxt = Data_In;
            end else if (w_drain) begin
                w_m_vld_nxt = 1'b0;
            end
        end else if (w_accept) begin
            // M is stalled and full: park the incoming entry in S.
            w_s_vld_nxt  = 1'b1;
            w_s_ctrl_nxt = Ctrl_In;
            w_s_data_nxt = Data_In;
        end
        w_occ_nxt = {1'b0, w_m_vld_nxt} + {1'b0, w_s_vld_nxt};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_m_vld  <= 1'b0;
            r_m_ctrl <= CTRL_RESET;
            r_m_data <= '0;
            r_s_vld  <= 1'b0;
            r_s_ctrl <= CTRL_RESET;
            r_s_data <= '0;
            r_occ    <= 2'd0;
        end else begin
            r_m_vld  <= w_m_vld_nxt;
            r_m_ctrl <= w_m_ctrl_nxt;
            r_m_data <= w_m_data_nxt;
            r_s_vld  <= w_s_vld_nxt;
            r_s_ctrl <= w_s_ctrl_nxt;
            r_s_data <= w_s_data_nxt;
            r_occ    <= w_occ_nxt;
        end
    end
`else
    logic r_occ;

    assign Ready_Out = ~r_m_vld | Ready_In;
    assign Occupancy = {1'b0, r_occ};

    always_comb begin
        w_m_vld_nxt  = r_m_vld;
        w_m_ctrl_nxt = r_m_ctrl;
        w_m_data_nxt = r_m_data;
        if (Flush) begin
            w_m_vld_nxt = 1'b0;
        end else if (w_accept) begin
            w_m_vld_nxt  = 1'b1;
            w_m_ctrl_nxt = Ctrl_In;
            w_m_data_nxt = Data_In;
        end else if (w_drain) begin
            w_m_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_m_vld  <= 1'b0;
            r_m_ctrl <= CTRL_RESET;
            r_m_data <= '0;
            r_occ    <= 1'b0;
        end else begin
            r_m_vld  <= w_m_vld_nxt;
            r_m_ctrl <= w_m_ctrl_nxt;
            r_m_data <= w_m_data_nxt;
            r_occ    <= w_m_vld_nxt;
        end
    end
`endif

endmodule
